datamover_cmd_arbiter: RTL and testbench
========================================

Name: datamover_cmd_arbiter

Overview:
- Shares one datamover command/status channel pair between NUM_STREAMS independent command producers.
- Producers are per-stream command queues, for example one per stream master.
- Grants commands round-robin and stamps each granted command's tag field with the stream index.
- Routes each returning status beat to its owner by tag, and caps the number of in-flight commands.

Parameters:
- C_STREAMS_WIDTH, 2, log2 of stream count; NUM_STREAMS = 1<<C_STREAMS_WIDTH, max 16.
- C_M_AXIS_CMD_DATA_WIDTH, 73, datamover command width; tag field is bits [67:64].
- C_M_AXIS_STS_DATA_WIDTH, 8, datamover status width; tag field is bits [3:0].
- C_MAX_OUTSTANDING, 4, maximum commands issued but not yet answered by status; range 1..15.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- S_AXIS_CMD_TVALID  in  NUM_STREAMS  per-stream command valid.
- S_AXIS_CMD_TREADY  out  NUM_STREAMS  per-stream command accept.
- S_AXIS_CMD_TDATA  in  NUM_STREAMS*73  per-stream command; stream m occupies slice [m*73+:73].
- M_AXIS_STS_TVALID  out  NUM_STREAMS  per-stream status valid.
- M_AXIS_STS_TREADY  in  NUM_STREAMS  per-stream status ready.
- M_AXIS_STS_TDATA  out  8  status beat, broadcast to all streams.
- M_AXIS_CMD_TVALID  out  1  to datamover.
- M_AXIS_CMD_TREADY  in  1  from datamover.
- M_AXIS_CMD_TDATA  out  73  to datamover.
- S_AXIS_STS_TVALID  in  1  from datamover.
- S_AXIS_STS_TREADY  out  1  to datamover.
- S_AXIS_STS_TDATA  in  8  from datamover.
- stream_enable  in  NUM_STREAMS  per-stream arbitration mask.
- outstanding  out  4  current count of in-flight commands.
- err_count  out  8  count of status protocol errors.
- debug  out  64  observability.

Behaviour:
- Reset is asserted asynchronously and released synchronously to clk. During reset:
  - state=ARB, last_grant=NUM_STREAMS-1, so stream 0 wins first.
  - outstanding=0 and err_count=0.
  - All TVALID and TREADY outputs are 0; debug is 0.
- State ARB:
  - Candidates are S_AXIS_CMD_TVALID & stream_enable.
  - Arbitration proceeds only if outstanding < C_MAX_OUTSTANDING.
  - Pick the first candidate searching from last_grant+1, modulo NUM_STREAMS.
  - Register the winner into grant and go to CMD.
  - With no candidates, or outstanding at the cap, stay in ARB.
- State CMD:
  - M_AXIS_CMD_TVALID=1.
  - M_AXIS_CMD_TDATA = the granted stream's slice, with bits [67:64] replaced by grant zero-extended to 4 bits.
  - S_AXIS_CMD_TREADY[grant] = M_AXIS_CMD_TREADY; all other bits are 0.
  - On handshake: outstanding+1, last_grant<=grant, go to ARB.
  - Latency: a request that is valid in ARB at cycle N gives TVALID at N+1. Maximum throughput is one command every 2 cycles.
  - Once asserted, TVALID holds with stable data until the handshake. This holds even if stream_enable drops mid-CMD.
- Status path is combinational, tag = S_AXIS_STS_TDATA[3:0]:
  - tag < NUM_STREAMS: M_AXIS_STS_TVALID[tag]=S_AXIS_STS_TVALID, S_AXIS_STS_TREADY=M_AXIS_STS_TREADY[tag]; other valids are 0.
  - tag >= NUM_STREAMS: S_AXIS_STS_TREADY=1 and the beat is dropped. err_count+1, saturating at 255.
  - M_AXIS_STS_TDATA = S_AXIS_STS_TDATA.
- Counter rules:
  - Every status handshake, routed or dropped, decrements outstanding.
  - A status handshake with outstanding=0 leaves outstanding at 0 and increments err_count.
  - Command handshake and status handshake in the same cycle leave outstanding unchanged.
  - outstanding never exceeds C_MAX_OUTSTANDING.
- Reset mid-CMD: TVALID drops immediately (asynchronous), and the pending command is neither consumed nor counted.
- debug layout:
  - [3:0] grant.
  - [7:4] last_grant.
  - [11:8] outstanding.
  - [12] state==CMD.
  - [20:13] err_count.
  - [36:21] candidate vector, zero-padded.
  - remaining bits 0.

Decomposition:
- Shared package dm_arb_pkg:
  - CMD_TAG_LSB=64, CMD_TAG_W=4, STS_TAG_LSB=0.
  - State encodings ARB=0, CMD=1.
  - MAX_STREAMS=16.
- Sub-module rr_arbiter (combinational): inputs req and last; outputs onehot, idx, any. Instantiated once.

Test Plan:
- Streams 0..3 all valid with cmds addr=0x1000*m and tag=0xF, ready always 1 -> grants issue in order 0,1,2,3,0 every 2 cycles; M_AXIS_CMD_TDATA[67:64]=0,1,2,3, and addresses pass through unchanged.
- C_MAX_OUTSTANDING=2, no status returned -> exactly 2 commands issued, outstanding=2, next stalls. Inject status tag=1 -> outstanding=1 and a third command issues 2 cycles later.
- Status 0x82 with M_AXIS_STS_TREADY[2]=0 for 3 cycles -> S_AXIS_STS_TREADY=0 while stalled; beat delivered only on stream 2, and only once ready rises.
- NUM_STREAMS=4, status tag=7 -> accepted immediately, no stream valid asserted, err_count=1. Status with outstanding=0 -> err_count=2, outstanding stays 0.
- stream_enable=4'b1010 with all streams valid -> only streams 1 and 3 are granted, alternating. Clearing bit 1 during CMD for stream 1 -> that command still completes.
- Command and status handshakes in the same cycle -> outstanding unchanged. Assert rst_n=0 mid-CMD -> M_AXIS_CMD_TVALID=0 in the same cycle; after release, stream 0 is granted first.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared constants and state encoding for the datamover command arbiter.
package dm_arb_pkg;

  localparam int CMD_TAG_LSB = 64;
  localparam int CMD_TAG_W   = 4;
  localparam int STS_TAG_LSB = 0;
  localparam int STS_TAG_W   = 4;
  localparam int MAX_STREAMS = 16;

  typedef enum logic {
    ARB = 1'b0,
    CMD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request after 'last', wrapping.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  // N is a power of two, so the W-bit add wraps the search index for free.
  always_comb begin
    logic [W-1:0] cand;
    cand   = '0;
    idx    = '0;
    any    = 1'b0;
    onehot = '0;
    for (int i = 1; i <= N; i++) begin
      cand = last + W'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/datamover_cmd_arbiter.sv
// Shares one datamover command/status channel pair between several streams.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   ARB   | pick next enabled requester, if below the in-flight cap
//   CMD   | present granted command (tag = stream index) until accepted
module datamover_cmd_arbiter
  import dm_arb_pkg::*;
#(
  parameter int C_STREAMS_WIDTH         = 2,
  parameter int C_M_AXIS_CMD_DATA_WIDTH = 73,
  parameter int C_M_AXIS_STS_DATA_WIDTH = 8,
  parameter int C_MAX_OUTSTANDING       = 4,
  localparam int NUM_STREAMS = 1 << C_STREAMS_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NUM_STREAMS-1:0]                         S_AXIS_CMD_TVALID,
  output logic [NUM_STREAMS-1:0]                         S_AXIS_CMD_TREADY,
  input  logic [NUM_STREAMS*C_M_AXIS_CMD_DATA_WIDTH-1:0] S_AXIS_CMD_TDATA,
  output logic [NUM_STREAMS-1:0]                         M_AXIS_STS_TVALID,
  input  logic [NUM_STREAMS-1:0]                         M_AXIS_STS_TREADY,
  output logic [C_M_AXIS_STS_DATA_WIDTH-1:0]             M_AXIS_STS_TDATA,
  output logic                                           M_AXIS_CMD_TVALID,
  input  logic                                           M_AXIS_CMD_TREADY,
  output logic [C_M_AXIS_CMD_DATA_WIDTH-1:0]             M_AXIS_CMD_TDATA,
  input  logic                                           S_AXIS_STS_TVALID,
  output logic                                           S_AXIS_STS_TREADY,
  input  logic [C_M_AXIS_STS_DATA_WIDTH-1:0]             S_AXIS_STS_TDATA,
  input  logic [NUM_STREAMS-1:0]                         stream_enable,
  output logic [3:0]                                     outstanding,
  output logic [7:0]                                     err_count,
  output logic [63:0]                                    debug
);

  localparam int SW = C_STREAMS_WIDTH;
  localparam int CW = C_M_AXIS_CMD_DATA_WIDTH;

  arb_state_t             state, state_nxt;
  logic [SW-1:0]          grant, last_grant, win_idx;
  logic [NUM_STREAMS-1:0] grant_onehot, win_onehot, cand;
  logic                   win_any, below_cap, arb_go;
  logic                   cmd_hs, sts_hs, tag_ok;
  logic [STS_TAG_W-1:0]   sts_tag;
  logic [CW-1:0]          cmd_slice;

  assign cand      = S_AXIS_CMD_TVALID & stream_enable;
  assign below_cap = outstanding < 4'(C_MAX_OUTSTANDING);
  assign arb_go    = (state == ARB) && win_any && below_cap;
  assign cmd_hs    = (state == CMD) && M_AXIS_CMD_TREADY;
  assign sts_hs    = S_AXIS_STS_TVALID && S_AXIS_STS_TREADY;
  assign sts_tag   = S_AXIS_STS_TDATA[STS_TAG_LSB +: STS_TAG_W];
  assign tag_ok    = {1'b0, sts_tag} < (STS_TAG_W + 1)'(NUM_STREAMS);
  assign cmd_slice = S_AXIS_CMD_TDATA[grant*CW +: CW];

  rr_arbiter #(.N(NUM_STREAMS), .W(SW)) u_rr (
    .req    (cand),
    .last   (last_grant),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nxt;
  end

  // Next-state: leave ARB on a grant, leave CMD on the datamover handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (arb_go) state_nxt = CMD;
      CMD:     if (M_AXIS_CMD_TREADY) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Grant capture; last_grant only advances once the command is really taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant        <= '0;
      grant_onehot <= '0;
      last_grant   <= SW'(NUM_STREAMS - 1);
    end else begin
      if (arb_go) begin
        grant        <= win_idx;
        grant_onehot <= win_onehot;
      end
      if (cmd_hs) last_grant <= grant;
    end
  end

  // In-flight and error counters; simultaneous cmd+sts handshakes cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      err_count   <= '0;
    end else begin
      if (cmd_hs && !sts_hs)
        outstanding <= outstanding + 4'd1;
      else if (!cmd_hs && sts_hs && (outstanding != 4'd0))
        outstanding <= outstanding - 4'd1;
      if (sts_hs && (!tag_ok || (outstanding == 4'd0)) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  // Command outputs: granted slice with the tag field overwritten by stream index.
  always_comb begin
    M_AXIS_CMD_TVALID = 1'b0;
    M_AXIS_CMD_TDATA  = '0;
    S_AXIS_CMD_TREADY = '0;
    if (state == CMD) begin
      M_AXIS_CMD_TVALID = 1'b1;
      M_AXIS_CMD_TDATA  = cmd_slice;
      M_AXIS_CMD_TDATA[CMD_TAG_LSB +: CMD_TAG_W] = CMD_TAG_W'(grant);
      S_AXIS_CMD_TREADY = grant_onehot & {NUM_STREAMS{M_AXIS_CMD_TREADY}};
    end
  end

  // Status routing by tag; unknown tags are swallowed. Gated so reset forces 0.
  always_comb begin
    M_AXIS_STS_TVALID = '0;
    M_AXIS_STS_TDATA  = S_AXIS_STS_TDATA;
    S_AXIS_STS_TREADY = 1'b0;
    if (rst_n) begin
      if (tag_ok) begin
        M_AXIS_STS_TVALID[sts_tag[SW-1:0]] = S_AXIS_STS_TVALID;
        S_AXIS_STS_TREADY = M_AXIS_STS_TREADY[sts_tag[SW-1:0]];
      end else begin
        S_AXIS_STS_TREADY = 1'b1;
      end
    end
  end

  // Observability bus.
  always_comb begin
    debug = '0;
    if (rst_n) begin
      debug[3:0]   = 4'(grant);
      debug[7:4]   = 4'(last_grant);
      debug[11:8]  = outstanding;
      debug[12]    = (state == CMD);
      debug[20:13] = err_count;
      debug[36:21] = 16'(cand);
    end
  end

endmodule

// File: tb/tb_datamover_cmd_arbiter.sv
// Scoreboard bench for datamover_cmd_arbiter (4 streams, in-flight cap of 2).
module tb_datamover_cmd_arbiter;

  localparam int SW   = 2;
  localparam int NS   = 4;
  localparam int CW   = 73;
  localparam int SDW  = 8;
  localparam int MAXO = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     S_AXIS_CMD_TVALID;
  logic [NS-1:0]     S_AXIS_CMD_TREADY;
  logic [NS*CW-1:0]  S_AXIS_CMD_TDATA;
  logic [NS-1:0]     M_AXIS_STS_TVALID;
  logic [NS-1:0]     M_AXIS_STS_TREADY;
  logic [SDW-1:0]    M_AXIS_STS_TDATA;
  logic              M_AXIS_CMD_TVALID;
  logic              M_AXIS_CMD_TREADY;
  logic [CW-1:0]     M_AXIS_CMD_TDATA;
  logic              S_AXIS_STS_TVALID;
  logic              S_AXIS_STS_TREADY;
  logic [SDW-1:0]    S_AXIS_STS_TDATA;
  logic [NS-1:0]     stream_enable;
  logic [3:0]        outstanding;
  logic [7:0]        err_count;
  logic [63:0]       debug;

  datamover_cmd_arbiter #(
    .C_STREAMS_WIDTH         (SW),
    .C_M_AXIS_CMD_DATA_WIDTH (CW),
    .C_M_AXIS_STS_DATA_WIDTH (SDW),
    .C_MAX_OUTSTANDING       (MAXO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .S_AXIS_CMD_TVALID (S_AXIS_CMD_TVALID),
    .S_AXIS_CMD_TREADY (S_AXIS_CMD_TREADY),
    .S_AXIS_CMD_TDATA  (S_AXIS_CMD_TDATA),
    .M_AXIS_STS_TVALID (M_AXIS_STS_TVALID),
    .M_AXIS_STS_TREADY (M_AXIS_STS_TREADY),
    .M_AXIS_STS_TDATA  (M_AXIS_STS_TDATA),
    .M_AXIS_CMD_TVALID (M_AXIS_CMD_TVALID),
    .M_AXIS_CMD_TREADY (M_AXIS_CMD_TREADY),
    .M_AXIS_CMD_TDATA  (M_AXIS_CMD_TDATA),
    .S_AXIS_STS_TVALID (S_AXIS_STS_TVALID),
    .S_AXIS_STS_TREADY (S_AXIS_STS_TREADY),
    .S_AXIS_STS_TDATA  (S_AXIS_STS_TDATA),
    .stream_enable     (stream_enable),
    .outstanding       (outstanding),
    .err_count         (err_count),
    .debug             (debug)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int strm; logic [CW-1:0] data; } cmd_exp_t;
  typedef struct { logic [NS-1:0] vec; logic [SDW-1:0] data; } sts_exp_t;

  cmd_exp_t cmd_q[$];
  sts_exp_t sts_q[$];
  int       cmd_cyc_q[$];
  cmd_exp_t ce;
  sts_exp_t se;
  logic [NS-1:0] ce_vec;
  int vectors = 0;
  int miscompares = 0;
  int n_cmd_hs = 0;
  int last_cmd_strm = 0;
  int last_sts_cyc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [CW-1:0] mk_cmd(input int m, input logic [3:0] tag);
    logic [CW-1:0] c;
    c = '0;
    c[63:0]  = 64'(m) * 64'h1000;
    c[67:64] = tag;
    return c;
  endfunction

  task automatic push_cmd(input int m);
    cmd_exp_t e;
    e.strm = m;
    e.data = mk_cmd(m, 4'(m));
    cmd_q.push_back(e);
  endtask

  task automatic push_sts(input logic [NS-1:0] vec, input logic [SDW-1:0] data);
    sts_exp_t e;
    e.vec  = vec;
    e.data = data;
    sts_q.push_back(e);
  endtask

  // Command monitor: every datamover-side command handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && M_AXIS_CMD_TVALID && M_AXIS_CMD_TREADY) begin
      if (cmd_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL cmd_unexpected: actual 0x%0h required none", M_AXIS_CMD_TDATA);
      end else begin
        ce = cmd_q.pop_front();
        ce_vec = '0;
        ce_vec[ce.strm] = 1'b1;
        check("cmd_tdata", M_AXIS_CMD_TDATA, ce.data);
        check("cmd_src_tready", S_AXIS_CMD_TREADY, ce_vec);
        last_cmd_strm = ce.strm;
      end
      n_cmd_hs++;
      cmd_cyc_q.push_back(cyc);
    end
  end

  // Status monitor: every datamover-side status handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && S_AXIS_STS_TVALID && S_AXIS_STS_TREADY) begin
      if (sts_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sts_unexpected: actual 0x%0h required none", S_AXIS_STS_TDATA);
      end else begin
        se = sts_q.pop_front();
        check("sts_route_vec", M_AXIS_STS_TVALID, se.vec);
        check("sts_tdata", M_AXIS_STS_TDATA, se.data);
      end
      last_sts_cyc = cyc;
    end
  end

  task automatic wait_cmd_hs(input int budget);
    int p;
    int k;
    p = n_cmd_hs;
    k = 0;
    while (n_cmd_hs == p && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_cmd_hs == p) fail_timeout("wait_cmd_hs");
  endtask

  // Auto-responding datamover: answers every accepted command one cycle later.
  task automatic run_until(input int target, input bit stop, input int budget);
    int  seen;
    int  k;
    bit  done;
    seen = n_cmd_hs;
    k = 0;
    done = 1'b0;
    M_AXIS_STS_TREADY = '1;
    while (!done && k < budget) begin
      @(posedge clk); #1;
      k++;
      S_AXIS_STS_TVALID = 1'b0;
      if (n_cmd_hs != seen) begin
        seen = n_cmd_hs;
        S_AXIS_STS_TDATA  = {4'hA, 4'(last_cmd_strm)};
        S_AXIS_STS_TVALID = 1'b1;
        push_sts(NS'(1) << last_cmd_strm, {4'hA, 4'(last_cmd_strm)});
      end
      if (n_cmd_hs >= target) begin
        if (stop) S_AXIS_CMD_TVALID = '0;
        else      M_AXIS_CMD_TREADY = 1'b0;
        if (!S_AXIS_STS_TVALID) done = 1'b1;
      end
    end
    if (!done) fail_timeout("run_until");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int i0;
    int p;
    int k;

    rst_n = 1'b0;
    for (int m = 0; m < NS; m++) S_AXIS_CMD_TDATA[m*CW +: CW] = mk_cmd(m, 4'hF);
    S_AXIS_CMD_TVALID = '1;
    stream_enable     = '1;
    M_AXIS_CMD_TREADY = 1'b1;
    M_AXIS_STS_TREADY = '1;
    S_AXIS_STS_TVALID = 1'b1;
    S_AXIS_STS_TDATA  = 8'h07;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_tvalid", M_AXIS_CMD_TVALID, 1'b0);
    check("rst_src_tready", S_AXIS_CMD_TREADY, 4'b0000);
    check("rst_sts_tvalid", M_AXIS_STS_TVALID, 4'b0000);
    check("rst_sts_tready", S_AXIS_STS_TREADY, 1'b0);
    check("rst_debug", debug, 64'h0);
    check("rst_outstanding", outstanding, 4'd0);
    check("rst_err", err_count, 8'd0);
    S_AXIS_STS_TVALID = 1'b0;
    S_AXIS_CMD_TVALID = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_debug", debug, 64'h30);

    // Round-robin 0,1,2,3,0, one command every two cycles
    push_cmd(0); push_cmd(1); push_cmd(2); push_cmd(3); push_cmd(0);
    i0 = cmd_cyc_q.size();
    S_AXIS_CMD_TVALID = '1;
    c0 = cyc;
    run_until(5, 1'b1, 60);
    if (cmd_cyc_q.size() >= i0 + 5) begin
      check("first_latency", 32'(cmd_cyc_q[i0] - c0), 32'd1);
      for (int i = 1; i < 5; i++)
        check("rr_interval", 32'(cmd_cyc_q[i0+i] - cmd_cyc_q[i0+i-1]), 32'd2);
    end else begin
      fail_timeout("rr_count");
    end
    check("rr_outstanding", outstanding, 4'd0);

    // Cap at 2 with no status, then one status frees a slot
    push_cmd(1); push_cmd(2); push_cmd(3);
    p = n_cmd_hs;
    S_AXIS_CMD_TVALID = '1;
    repeat (12) begin @(posedge clk); #1; end
    check("cap_issued", 32'(n_cmd_hs - p), 32'd2);
    check("cap_outstanding", outstanding, 4'd2);
    check("cap_stall_tvalid", M_AXIS_CMD_TVALID, 1'b0);
    check("cap_candidates", debug[36:21], 16'h000F);
    push_sts(4'b0010, 8'h51);
    S_AXIS_STS_TDATA  = 8'h51;
    S_AXIS_STS_TVALID = 1'b1;
    @(posedge clk); #1;
    S_AXIS_STS_TVALID = 1'b0;
    check("cap_after_sts", outstanding, 4'd1);
    wait_cmd_hs(10);
    S_AXIS_CMD_TVALID = '0;
    check("cap_resume_delay", 32'(cmd_cyc_q[$] - last_sts_cyc), 32'd2);
    check("cap_refill", outstanding, 4'd2);

    // Status backpressure on stream 2
    M_AXIS_STS_TREADY = 4'b1011;
    S_AXIS_STS_TDATA  = 8'h82;
    S_AXIS_STS_TVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_sts_tready", S_AXIS_STS_TREADY, 1'b0);
      check("bp_route_vec", M_AXIS_STS_TVALID, 4'b0100);
    end
    push_sts(4'b0100, 8'h82);
    @(posedge clk); #1;
    M_AXIS_STS_TREADY = '1;
    @(posedge clk); #1;
    S_AXIS_STS_TVALID = 1'b0;
    check("bp_outstanding", outstanding, 4'd1);

    // Bad tag is swallowed; status with nothing in flight is an error
    M_AXIS_STS_TREADY = '0;
    S_AXIS_STS_TDATA  = 8'h07;
    S_AXIS_STS_TVALID = 1'b1;
    push_sts(4'b0000, 8'h07);
    @(negedge clk);
    check("badtag_tready", S_AXIS_STS_TREADY, 1'b1);
    @(posedge clk); #1;
    S_AXIS_STS_TVALID = 1'b0;
    check("badtag_err", err_count, 8'd1);
    check("badtag_outstanding", outstanding, 4'd0);
    M_AXIS_STS_TREADY = '1;
    S_AXIS_STS_TDATA  = 8'h30;
    S_AXIS_STS_TVALID = 1'b1;
    push_sts(4'b0001, 8'h30);
    @(posedge clk); #1;
    S_AXIS_STS_TVALID = 1'b0;
    check("underflow_err", err_count, 8'd2);
    check("underflow_outstanding", outstanding, 4'd0);

    // Enable mask 1010; disable stream 1 while its command is pending
    stream_enable = 4'b1010;
    S_AXIS_CMD_TVALID = '1;
    M_AXIS_CMD_TREADY = 1'b1;
    push_cmd(1); push_cmd(3); push_cmd(1); push_cmd(3);
    p = n_cmd_hs;
    run_until(p + 2, 1'b0, 40);
    check("mask_pend_tvalid", M_AXIS_CMD_TVALID, 1'b1);
    check("mask_pend_tdata", M_AXIS_CMD_TDATA, mk_cmd(1, 4'd1));
    check("mask_pend_src_tready", S_AXIS_CMD_TREADY, 4'b0000);
    stream_enable = 4'b1000;
    repeat (2) begin @(posedge clk); #1; end
    check("mask_hold_tvalid", M_AXIS_CMD_TVALID, 1'b1);
    check("mask_hold_tdata", M_AXIS_CMD_TDATA, mk_cmd(1, 4'd1));
    check("mask_candidates", debug[36:21], 16'h0008);
    M_AXIS_CMD_TREADY = 1'b1;
    run_until(p + 4, 1'b1, 40);
    check("mask_outstanding", outstanding, 4'd0);

    // Command and status handshakes in the same cycle
    stream_enable     = '1;
    S_AXIS_CMD_TVALID = 4'b0001;
    push_cmd(0); push_cmd(0);
    wait_cmd_hs(10);
    check("same_pre", outstanding, 4'd1);
    @(posedge clk); #1;
    check("same_cmd_pending", M_AXIS_CMD_TVALID, 1'b1);
    S_AXIS_STS_TDATA  = 8'hC0;
    S_AXIS_STS_TVALID = 1'b1;
    push_sts(4'b0001, 8'hC0);
    p = n_cmd_hs;
    @(posedge clk); #1;
    S_AXIS_STS_TVALID = 1'b0;
    S_AXIS_CMD_TVALID = '0;
    check("same_cmd_taken", 32'(n_cmd_hs - p), 32'd1);
    check("same_outstanding", outstanding, 4'd1);
    S_AXIS_STS_TVALID = 1'b1;
    push_sts(4'b0001, 8'hC0);
    @(posedge clk); #1;
    S_AXIS_STS_TVALID = 1'b0;
    check("drain_outstanding", outstanding, 4'd0);

    // err_count saturates at 255
    S_AXIS_STS_TDATA = 8'h07;
    for (int i = 0; i < 260; i++) begin
      push_sts(4'b0000, 8'h07);
      S_AXIS_STS_TVALID = 1'b1;
      @(posedge clk); #1;
    end
    S_AXIS_STS_TVALID = 1'b0;
    check("err_saturate", err_count, 8'hFF);
    check("err_sat_outstanding", outstanding, 4'd0);

    // Reset in the middle of a pending command
    M_AXIS_CMD_TREADY = 1'b0;
    S_AXIS_CMD_TVALID = 4'b0010;
    k = 0;
    while (!M_AXIS_CMD_TVALID && k < 10) begin @(posedge clk); #1; k++; end
    check("rstmid_pending", M_AXIS_CMD_TVALID, 1'b1);
    p = n_cmd_hs;
    rst_n = 1'b0;
    #1;
    M_AXIS_CMD_TREADY = 1'b1;
    #1;
    check("rstmid_tvalid", M_AXIS_CMD_TVALID, 1'b0);
    check("rstmid_src_tready", S_AXIS_CMD_TREADY, 4'b0000);
    repeat (2) begin @(posedge clk); #1; end
    check("rstmid_not_counted", 32'(n_cmd_hs - p), 32'd0);
    check("rstmid_outstanding", outstanding, 4'd0);
    check("rstmid_err", err_count, 8'd0);
    rst_n = 1'b1;
    push_cmd(0); push_cmd(1);
    S_AXIS_CMD_TVALID = '1;
    run_until(p + 2, 1'b1, 40);

    repeat (3) begin @(posedge clk); #1; end
    check("end_cmd_queue_empty", 32'(cmd_q.size()), 32'd0);
    check("end_sts_queue_empty", 32'(sts_q.size()), 32'd0);
    check("end_outstanding", outstanding, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
